vm_ctrl_param: RTL and testbench

Parametrised vending-machine controller, the next generation of the single-key vending FSM in the board-level design. It takes three coin channels and a cancel key, all active-low push-buttons, and debounces each one. Credit accumulates against a parametrised price. On reaching the price it vends and reports change; on cancel it refunds the full credit. It sits between the board keys and the LED/display logic in the DE-board top level.

---
 rtl/vm_ctrl_param.sv | 196 +++++++++++++++++++
 tb/tb_vm_ctrl_param.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_ctrl_param.sv
// rtl/vm_ctrl_param.sv - debounced three-coin vending controller; optional LED map under VM_LED_MAP_EN
module vm_ctrl_param_db #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          armed;
    logic          pressed;
    logic [CW-1:0] cnt;
    logic          counting;

    // Until armed, the key must first be seen released, so a key held through reset never fires.
    assign counting = armed ? (s2 == pressed) : s2;
    assign press    = armed & ~pressed & ~s2 & (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            armed   <= 1'b0;
            pressed <= 1'b0;
            cnt     <= '0;
        end else begin
            s1 <= key;
            s2 <= s1;
            if (!counting) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt <= '0;
                if (!armed)
                    armed <= 1'b1;
                else
                    pressed <= ~pressed;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module vm_ctrl_param #(
    parameter int CREDIT_W    = 8,
    parameter int PRICE       = 25,
    parameter int COIN_A      = 5,
    parameter int COIN_B      = 10,
    parameter int COIN_C      = 25,
    parameter int DB_CYCLES   = 4,
    parameter int DISP_CYCLES = 30
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [2:0]          KEY_COIN,
    input  logic                KEY_CANCEL,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] change,
    output logic                vend,
    output logic                refund,
    output logic                busy,
    output logic                coin_reject
`ifdef VM_LED_MAP_EN
    ,
    output logic [12:0]         LEDR,
    output logic [7:0]          LEDG
`endif
);
    localparam int DW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES + 1) : 1;
    localparam logic [DW-1:0]       DLAST   = DW'(DISP_CYCLES - 1);
    localparam logic [CREDIT_W:0]   MAXC    = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W:0]   VAL_A   = (CREDIT_W + 1)'(COIN_A);
    localparam logic [CREDIT_W:0]   VAL_B   = (CREDIT_W + 1)'(COIN_B);
    localparam logic [CREDIT_W:0]   VAL_C   = (CREDIT_W + 1)'(COIN_C);

    typedef enum logic [1:0] {IDLE, ACCUM, VEND, REFUND} state_t;

    state_t              state;
    logic [3:0]          raw;
    logic [3:0]          pulse;
    logic                coin_hit;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W:0]   diff;
    logic [DW-1:0]       disp_cnt;

    assign raw = {KEY_CANCEL, KEY_COIN};

    for (genvar g = 0; g < 4; g++) begin : g_db
        vm_ctrl_param_db #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (CLOCK_50),
            .rst_n (RESET_N),
            .key   (raw[g]),
            .press (pulse[g])
        );
    end

    // Lowest-index coin wins when several fire together.
    always_comb begin
        coin_hit = |pulse[2:0];
        coin_val = VAL_C;
        if (pulse[0])
            coin_val = VAL_A;
        else if (pulse[1])
            coin_val = VAL_B;
        sum  = {1'b0, credit} + coin_val;
        diff = sum - PRICE_X;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            credit      <= '0;
            change      <= '0;
            vend        <= 1'b0;
            refund      <= 1'b0;
            busy        <= 1'b0;
            coin_reject <= 1'b0;
            disp_cnt    <= '0;
        end else begin
            coin_reject <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    if (state == ACCUM && pulse[3]) begin
                        state    <= REFUND;
                        change   <= credit;
                        credit   <= '0;
                        refund   <= 1'b1;
                        busy     <= 1'b1;
                        disp_cnt <= '0;
                    end else if (coin_hit) begin
                        if (sum > MAXC) begin
                            coin_reject <= 1'b1;
                        end else if (sum >= PRICE_X) begin
                            state    <= VEND;
                            credit   <= '0;
                            change   <= diff[CREDIT_W-1:0];
                            vend     <= 1'b1;
                            busy     <= 1'b1;
                            disp_cnt <= '0;
                        end else begin
                            state  <= ACCUM;
                            credit <= sum[CREDIT_W-1:0];
                        end
                    end
                end
                VEND, REFUND: begin
                    if (disp_cnt == DLAST) begin
                        state  <= IDLE;
                        change <= '0;
                        vend   <= 1'b0;
                        refund <= 1'b0;
                        busy   <= 1'b0;
                    end else begin
                        disp_cnt <= disp_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VM_LED_MAP_EN
    localparam int EW = (CREDIT_W > 13) ? CREDIT_W : 13;
    localparam int XW = (CREDIT_W > 5) ? CREDIT_W : 5;
    localparam logic [DW-1:0] DFULL = DW'(DISP_CYCLES);

    logic [EW-1:0] credit_ext;
    logic [XW-1:0] change_ext;
    logic [DW-1:0] rej_cnt;

    assign credit_ext = EW'(credit);
    assign change_ext = XW'(change);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            LEDR    <= '0;
            LEDG    <= '0;
            rej_cnt <= '0;
        end else begin
            if (coin_reject)
                rej_cnt <= DFULL;
            else if (rej_cnt != '0)
                rej_cnt <= rej_cnt - 1'b1;
            LEDR <= credit_ext[12:0];
            LEDG <= {change_ext[4:0], (rej_cnt != '0), refund, vend};
        end
    end
`endif
endmodule

// File: tb/tb_vm_ctrl_param.sv
// tb/tb_vm_ctrl_param.sv - directed bench with cycle-level behavioural model for vm_ctrl_param
module tb_vm_ctrl_param;
    localparam int DB   = 4;
    localparam int DISP = 30;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] k0 = 4'hF;
    logic [3:0] k1 = 4'hF;
    logic chk_en = 1'b1;

    wire [7:0] cr0, ch0;
    wire       v0, r0, b0, j0;
    wire [4:0] cr1, ch1;
    wire       v1, r1, b1, j1;
`ifdef VM_LED_MAP_EN
    wire [12:0] ledr0, ledr1;
    wire [7:0]  ledg0, ledg1;
`endif

    int checks = 0;
    int errors = 0;
    int rej_seen1 = 0;

    always #5 clk = ~clk;

    vm_ctrl_param u_dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .KEY_COIN(k0[2:0]), .KEY_CANCEL(k0[3]),
        .credit(cr0), .change(ch0), .vend(v0), .refund(r0), .busy(b0), .coin_reject(j0)
`ifdef VM_LED_MAP_EN
        , .LEDR(ledr0), .LEDG(ledg0)
`endif
    );

    vm_ctrl_param #(.CREDIT_W(5), .PRICE(31)) u_small (
        .CLOCK_50(clk), .RESET_N(rst_n), .KEY_COIN(k1[2:0]), .KEY_CANCEL(k1[3]),
        .credit(cr1), .change(ch1), .vend(v1), .refund(r1), .busy(b1), .coin_reject(j1)
`ifdef VM_LED_MAP_EN
        , .LEDR(ledr1), .LEDG(ledg1)
`endif
    );

    // Model: each key is seen two samples late; an event needs DB equal samples in a row.
    int m_credit[2], m_change[2], m_left[2];
    bit m_isvend[2], m_rej[2];
    int run[2][4];
    bit lastdl[2][4], kpressed[2][4], armed[2][4], h1[2][4], h2[2][4];

    function automatic int cval(input int k);
        case (k)
            0:       return 5;
            1:       return 10;
            default: return 25;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit dl;
        bit ev[4];
        int v, n, maxc, price;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 4; k++) begin
                    h1[d][k] = 1; h2[d][k] = 1; lastdl[d][k] = 1;
                    run[d][k] = 0; kpressed[d][k] = 0; armed[d][k] = 0;
                end
                m_credit[d] = 0; m_change[d] = 0; m_left[d] = 0;
                m_isvend[d] = 0; m_rej[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                maxc  = (d == 0) ? 255 : 31;
                price = (d == 0) ? 25 : 31;
                for (int k = 0; k < 4; k++) begin
                    dl = h2[d][k];
                    h2[d][k] = h1[d][k];
                    h1[d][k] = (d == 0) ? k0[k] : k1[k];
                    run[d][k] = (dl == lastdl[d][k]) ? run[d][k] + 1 : 1;
                    lastdl[d][k] = dl;
                    ev[k] = 0;
                    if (run[d][k] == DB) begin
                        if (!armed[d][k]) begin
                            if (dl) armed[d][k] = 1;
                        end else if (!kpressed[d][k] && !dl) begin
                            ev[k] = 1;
                            kpressed[d][k] = 1;
                        end else if (kpressed[d][k] && dl) begin
                            kpressed[d][k] = 0;
                        end
                    end
                end
                m_rej[d] = 0;
                if (m_left[d] > 0) begin
                    m_left[d]--;
                    if (m_left[d] == 0) m_change[d] = 0;
                end else if (ev[3] && m_credit[d] > 0) begin
                    m_change[d] = m_credit[d];
                    m_credit[d] = 0;
                    m_left[d] = DISP;
                    m_isvend[d] = 0;
                end else if (ev[0] || ev[1] || ev[2]) begin
                    v = ev[0] ? cval(0) : (ev[1] ? cval(1) : cval(2));
                    n = m_credit[d] + v;
                    if (n > maxc) begin
                        m_rej[d] = 1;
                    end else if (n >= price) begin
                        m_change[d] = n - price;
                        m_credit[d] = 0;
                        m_left[d] = DISP;
                        m_isvend[d] = 1;
                    end else begin
                        m_credit[d] = n;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int d);
        int a_cr, a_ch, a_v, a_r, a_b, a_j;
        a_cr = (d == 0) ? int'(cr0) : int'(cr1);
        a_ch = (d == 0) ? int'(ch0) : int'(ch1);
        a_v  = (d == 0) ? int'(v0) : int'(v1);
        a_r  = (d == 0) ? int'(r0) : int'(r1);
        a_b  = (d == 0) ? int'(b0) : int'(b1);
        a_j  = (d == 0) ? int'(j0) : int'(j1);
        check($sformatf("dut%0d credit", d), a_cr, m_credit[d]);
        check($sformatf("dut%0d change", d), a_ch, m_change[d]);
        check($sformatf("dut%0d vend", d), a_v, int'(m_left[d] > 0 && m_isvend[d]));
        check($sformatf("dut%0d refund", d), a_r, int'(m_left[d] > 0 && !m_isvend[d]));
        check($sformatf("dut%0d busy", d), a_b, int'(m_left[d] > 0));
        check($sformatf("dut%0d coin_reject", d), a_j, int'(m_rej[d]));
        check($sformatf("dut%0d exclusive", d), a_v & a_r, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0);
            cmp(1);
        end
        if (j1) rej_seen1++;
    end

    task automatic press(input int d, input logic [3:0] mask);
        @(posedge clk); #2;
        if (d == 0) k0 = k0 & ~mask; else k1 = k1 & ~mask;
        repeat (12) @(posedge clk);
        #2;
        if (d == 0) k0 = k0 | mask; else k1 = k1 | mask;
        repeat (12) @(posedge clk);
    endtask

    task automatic wait_vend();
        int n;
        n = 0;
        while (!v0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("vend_seen", int'(v0), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset credit", int'(cr0), 0);
        check("reset busy", int'(b0), 0);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // five A coins: 5,10,15,20 then vend with change 0
        for (int i = 0; i < 4; i++) press(0, 4'b0001);
        @(negedge clk);
        check("A x4 credit", int'(cr0), 20);
        press(0, 4'b0001);
        @(negedge clk);
        check("A x5 vend", int'(v0), 1);
        check("A x5 change", int'(ch0), 0);
        check("A x5 credit", int'(cr0), 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("A x5 done", int'(v0), 0);

        // three B coins: vend with change 5, coin during vend dropped
        press(0, 4'b0010);
        press(0, 4'b0010);
        @(negedge clk);
        check("B x2 credit", int'(cr0), 20);
        press(0, 4'b0010);
        press(0, 4'b0001);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("B x3 idle credit", int'(cr0), 0);
        check("B x3 idle busy", int'(b0), 0);

        // A, B, cancel: refund 15
        press(0, 4'b0001);
        press(0, 4'b0010);
        press(0, 4'b1000);
        @(negedge clk);
        check("cancel refund", int'(r0), 1);
        check("cancel change", int'(ch0), 15);
        check("cancel vend", int'(v0), 0);
        repeat (20) @(posedge clk);

        // glitch of 2 cycles ignored
        @(posedge clk); #2 k0[1] = 1'b0;
        repeat (2) @(posedge clk);
        #2 k0[1] = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("glitch credit", int'(cr0), 0);

        // long hold: exactly one +10, six cycles after the falling edge
        @(posedge clk); #2 k0[1] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("latency edge5", int'(cr0), 0);
        @(posedge clk);
        @(negedge clk);
        check("latency edge6", int'(cr0), 10);
        repeat (92) @(posedge clk);
        #2 k0[1] = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("long hold credit", int'(cr0), 10);
        press(0, 4'b1000);
        repeat (20) @(posedge clk);

        // narrow datapath: overflow rejects and simultaneous coins
        for (int i = 0; i < 5; i++) press(1, 4'b0001);
        @(negedge clk);
        check("small A x5", int'(cr1), 25);
        press(1, 4'b0100);
        @(negedge clk);
        check("small C credit", int'(cr1), 25);
        check("small C rejects", rej_seen1, 1);
        press(1, 4'b0001);
        @(negedge clk);
        check("small A credit", int'(cr1), 30);
        press(1, 4'b0011);
        @(negedge clk);
        check("small AB credit", int'(cr1), 30);
        check("small AB rejects", rej_seen1, 2);
        press(1, 4'b1000);
        @(negedge clk);
        check("small refund", int'(r1), 1);
        check("small refund change", int'(ch1), 30);
        repeat (20) @(posedge clk);

        // asynchronous reset mid-vend with keys held through reset
        press(0, 4'b0010);
        press(0, 4'b0010);
        @(posedge clk); #2 k0[1] = 1'b0;
        wait_vend();
        #1 k0[0] = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async vend", int'(v0), 0);
        check("async change", int'(ch0), 0);
        check("async busy", int'(b0), 0);
        check("async credit", int'(cr0), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("held key credit", int'(cr0), 0);
        check("held key busy", int'(b0), 0);
        #1 k0 = 4'hF;
        repeat (12) @(posedge clk);
        press(0, 4'b0001);
        @(negedge clk);
        check("re-press credit", int'(cr0), 5);
        press(0, 4'b1000);
        repeat (10) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
